// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and scan state encoding for the 7-segment scanner
package seg7_pkg;

    localparam int          NUM_DIGITS = 4;
    // Segments are active-low {g,f,e,d,c,b,a}; all ones leaves the digit dark.
    localparam logic [6:0]  SEG_OFF    = 7'h7F;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } seg7_state_t;

endpackage

// File: rtl/bcd_to_7seg.sv
// rtl/bcd_to_7seg.sv - 4-bit code to active-low {g,f,e,d,c,b,a} segment pattern
module bcd_to_7seg (
    input  logic [3:0] BCD,
    output logic [6:0] seg
);

    // Codes above 9 decode to hex glyphs; the scanner decides whether to show them.
    always_comb begin
        seg = 7'h7F;
        case (BCD)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - four-digit multiplexed 7-segment scanner with
// dead-time gaps, frame-aligned display updates and leading-zero blanking
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int TICK_DIV = 50000,
    parameter int DEAD_CYC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    output logic        ready,
    input  logic [15:0] data_in,
    input  logic        blank_lz,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        frame_start
);

    localparam int              CNT_W     = $clog2((TICK_DIV > DEAD_CYC) ? TICK_DIV : DEAD_CYC);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYC - 1);

    seg7_state_t        r_state;
    seg7_state_t        w_state_nxt;
    logic [1:0]         r_idx;
    logic [1:0]         w_idx_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_frame_entry;

    logic [15:0]        r_disp;
    logic [15:0]        r_pend;
    logic               r_pend_vld;
    logic [6:0]         r_seg;
    logic [3:0]         r_an;
    logic               r_frame_start;

    logic [3:0]         w_bcd;
    logic [6:0]         w_dec_seg;
    logic               w_z3;
    logic               w_z32;
    logic               w_z321;
    logic               w_lz_blank;
    logic [6:0]         w_seg_nxt;
    logic [3:0]         w_an_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= OFF;
            r_idx   <= 2'd0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_cnt_nxt     = r_cnt + 1'b1;
        w_frame_entry = 1'b0;
        if (!en) begin
            w_state_nxt = OFF;
            w_idx_nxt   = 2'd0;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                OFF: begin
                    w_state_nxt   = BLANK;
                    w_idx_nxt     = 2'd0;
                    w_cnt_nxt     = '0;
                    w_frame_entry = 1'b1;
                end
                BLANK: begin
                    if (r_cnt == DEAD_LAST) begin
                        w_state_nxt = SHOW;
                        w_cnt_nxt   = '0;
                    end
                end
                SHOW: begin
                    if (r_cnt == TICK_LAST) begin
                        w_state_nxt   = BLANK;
                        w_idx_nxt     = r_idx + 2'd1;
                        w_cnt_nxt     = '0;
                        w_frame_entry = (r_idx == 2'd3);
                    end
                end
                default: begin
                    w_state_nxt = OFF;
                    w_idx_nxt   = 2'd0;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Outputs are computed from the next state so seg/an register alongside it.
    assign w_bcd = r_disp[{w_idx_nxt, 2'b00} +: 4];

    bcd_to_7seg u_dec (
        .BCD (w_bcd),
        .seg (w_dec_seg)
    );

    assign w_z3   = (r_disp[15:12] == 4'd0);
    assign w_z32  = w_z3  && (r_disp[11:8] == 4'd0);
    assign w_z321 = w_z32 && (r_disp[7:4]  == 4'd0);

    always_comb begin
        w_lz_blank = 1'b0;
        case (w_idx_nxt)
            2'd3:    w_lz_blank = blank_lz && w_z3;
            2'd2:    w_lz_blank = blank_lz && w_z32;
            2'd1:    w_lz_blank = blank_lz && w_z321;
            default: w_lz_blank = 1'b0;
        endcase
    end

    always_comb begin
        w_an_nxt  = 4'hF;
        w_seg_nxt = SEG_OFF;
        if (w_state_nxt == SHOW) begin
            w_an_nxt = ~(4'b0001 << w_idx_nxt);
            if ((w_bcd <= 4'd9) && !w_lz_blank) begin
                w_seg_nxt = w_dec_seg;
            end
        end
    end

    // A pending value blocks new loads until the next frame boundary takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_disp        <= 16'h0000;
            r_pend        <= 16'h0000;
            r_pend_vld    <= 1'b0;
            r_seg         <= SEG_OFF;
            r_an          <= 4'hF;
            r_frame_start <= 1'b0;
        end else begin
            r_seg         <= w_seg_nxt;
            r_an          <= w_an_nxt;
            r_frame_start <= w_frame_entry;
            if (w_frame_entry && r_pend_vld) begin
                r_disp     <= r_pend;
                r_pend_vld <= 1'b0;
            end else if (load && !r_pend_vld) begin
                r_pend     <= data_in;
                r_pend_vld <= 1'b1;
            end
        end
    end

    assign ready       = ~r_pend_vld;
    assign seg         = r_seg;
    assign an          = r_an;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - frame-level scoreboard bench for seg7_scan_ctrl
module tb_seg7_scan_ctrl;

    localparam int         TICK  = 8;
    localparam int         DEAD  = 2;
    localparam int         SLOT  = TICK + DEAD;
    localparam int         FRAME = 4 * SLOT;
    localparam logic [6:0] S_OFF = 7'h7F;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        load;
    logic [15:0] data_in;
    logic        blank_lz;
    logic        ready;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_start;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q[$];
    logic [15:0] cur_disp;

    seg7_scan_ctrl #(.TICK_DIV(TICK), .DEAD_CYC(DEAD)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .load        (load),
        .ready       (ready),
        .data_in     (data_in),
        .blank_lz    (blank_lz),
        .seg         (seg),
        .an          (an),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] dec(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return S_OFF;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input logic [15:0] v, input int k, input logic blz);
        logic [3:0] d;
        d = v[k*4 +: 4];
        if (d > 4'd9) return S_OFF;
        if (blz && (k > 0) && ((v >> (4*k)) == 16'h0)) return S_OFF;
        return dec(d);
    endfunction

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_frame(input logic blz, input bit immediate,
                             input int ld1_c, input logic [15:0] ld1_d,
                             input int ld2_c, input logic [15:0] ld2_d);
        int         waited;
        bit         exp_ready;
        int         slot;
        int         pos;
        logic [3:0] exp_an;
        logic [6:0] exp_sg;
        waited   = 0;
        blank_lz = blz;
        while (!frame_start && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check_value("frame_start_seen", {31'd0, frame_start}, 32'd1);
        if (immediate) check_value("frame_period", waited, 32'd0);
        if (exp_q.size() > 0) cur_disp = exp_q.pop_front();
        exp_ready = 1'b1;
        for (int c = 0; c < FRAME; c++) begin
            slot   = c / SLOT;
            pos    = c % SLOT;
            exp_an = 4'hF;
            exp_sg = S_OFF;
            if (pos >= DEAD) begin
                exp_an[slot] = 1'b0;
                exp_sg       = exp_seg(cur_disp, slot, blz);
            end
            check_value($sformatf("an d=%h c=%0d", cur_disp, c), {28'd0, an}, {28'd0, exp_an});
            check_value($sformatf("seg d=%h c=%0d", cur_disp, c), {25'd0, seg}, {25'd0, exp_sg});
            check_value($sformatf("frame_start c=%0d", c), {31'd0, frame_start}, {31'd0, (c == 0)});
            check_value($sformatf("ready c=%0d", c), {31'd0, ready}, {31'd0, exp_ready});
            load = 1'b0;
            if (c == ld1_c) begin
                load    = 1'b1;
                data_in = ld1_d;
            end else if (c == ld2_c) begin
                load    = 1'b1;
                data_in = ld2_d;
            end
            if (load && exp_ready) begin
                exp_q.push_back(data_in);
                exp_ready = 1'b0;
            end
            @(negedge clk);
        end
        load = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        load     = 1'b0;
        data_in  = 16'h0;
        blank_lz = 1'b0;
        cur_disp = 16'h0;
        repeat (2) @(negedge clk);
        check_value("rst an", {28'd0, an}, 32'hF);
        check_value("rst seg", {25'd0, seg}, {25'd0, S_OFF});
        check_value("rst ready", {31'd0, ready}, 32'd1);
        check_value("rst frame_start", {31'd0, frame_start}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_value("off an", {28'd0, an}, 32'hF);
        en = 1'b1;

        run_frame(1'b0, 1'b0,  5, 16'h1234, -1, 16'h0);
        run_frame(1'b0, 1'b1, 10, 16'h0007, -1, 16'h0);
        run_frame(1'b1, 1'b1, -1, 16'h0,    -1, 16'h0);
        run_frame(1'b0, 1'b1,  3, 16'h5678, 39, 16'h9999);
        run_frame(1'b0, 1'b1,  0, 16'h00A0, -1, 16'h0);
        run_frame(1'b0, 1'b1, 25, 16'h1020, -1, 16'h0);
        run_frame(1'b1, 1'b1, -1, 16'h0,    -1, 16'h0);

        // Drop enable for one cycle while digit 2 is lit.
        repeat (2 * SLOT + DEAD + 2) @(negedge clk);
        check_value("endrop an idx2", {28'd0, an}, 32'hB);
        en = 1'b0;
        @(negedge clk);
        check_value("endrop an", {28'd0, an}, 32'hF);
        check_value("endrop seg", {25'd0, seg}, {25'd0, S_OFF});
        check_value("endrop frame_start", {31'd0, frame_start}, 32'd0);
        en = 1'b1;
        @(negedge clk);
        check_value("reen frame_start", {31'd0, frame_start}, 32'd1);
        check_value("reen an", {28'd0, an}, 32'hF);
        run_frame(1'b0, 1'b1, -1, 16'h0, -1, 16'h0);

        // Reset mid-frame while a pending value is held.
        repeat (3) @(negedge clk);
        load    = 1'b1;
        data_in = 16'h4321;
        @(negedge clk);
        load = 1'b0;
        check_value("pend ready", {31'd0, ready}, 32'd0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_value("midrst an", {28'd0, an}, 32'hF);
        check_value("midrst seg", {25'd0, seg}, {25'd0, S_OFF});
        check_value("midrst ready", {31'd0, ready}, 32'd1);
        check_value("midrst frame_start", {31'd0, frame_start}, 32'd0);
        rst = 1'b0;
        exp_q.delete();
        cur_disp = 16'h0;
        run_frame(1'b0, 1'b0, -1, 16'h0, -1, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000: clock cycles each digit is lit per slot (legal range 2..2^20).
REQ-002 SHALL have parameter DEAD_CYC, default 4: all-anodes-off cycles before each digit slot, for anti-ghosting (legal range 1..255).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port en, input, 1 bit: scan enable; low holds the display dark.
REQ-006 SHALL have port load, input, 1 bit: valid strobe for data_in.
REQ-007 SHALL have port ready, output, 1 bit: high when the pending register is free and a load will be accepted.
REQ-008 SHALL have port data_in, input, 16 bits: four BCD digits, [3:0] = digit 0 (rightmost).
REQ-009 SHALL have port blank_lz, input, 1 bit: leading-zero blanking enable.
REQ-010 SHALL have port seg, output, 7 bits: segment drive, the bcd_to_7seg encoding unchanged, or SEG_OFF when blanked.
REQ-011 SHALL have port an, output, 4 bits: active-low digit enables, an[i] selects digit i.
REQ-012 SHALL have port frame_start, output, 1 bit: one-cycle pulse when a new scan frame starts.

Function
REQ-013 SHALL implement states OFF, BLANK, SHOW, with a 2-bit digit index idx and a slot counter.
REQ-014 In OFF: an=4'b1111 and seg=SEG_OFF; when en=1 the next state SHALL be BLANK with idx=0.
REQ-015 In BLANK: an=4'b1111 and seg=SEG_OFF for exactly DEAD_CYC cycles, then the next state SHALL be SHOW.
REQ-016 In SHOW: an[idx]=0, all other anodes 1, for exactly TICK_DIV cycles; then idx SHALL increment modulo 4 and the next state SHALL be BLANK.
REQ-017 Frame period SHALL be exactly 4*(DEAD_CYC+TICK_DIV) cycles.
REQ-018 en=0 in any state SHALL force OFF on the next edge; re-enable SHALL restart at BLANK with idx=0.
REQ-019 Handshake: load=1 with ready=1 SHALL capture data_in into the pending register and drive ready=0 on the next cycle.
REQ-020 A load while ready=0 SHALL be ignored, with no state change.
REQ-021 Commit: on entry to BLANK with idx=0 (from OFF, or on the 3->0 wrap), a valid pending value SHALL be copied to the display register, ready SHALL go 1, and frame_start SHALL pulse in that same cycle.
REQ-022 If load coincides with the commit cycle, the old pending value SHALL commit; the new load is refused because ready is still 0 that cycle.
REQ-023 Display contents SHALL change only at frame boundaries (no tearing within a frame).
REQ-024 The seg value for the lit digit SHALL come from one shared bcd_to_7seg decoder, with its input muxed by idx.
REQ-025 seg and an SHALL be registered outputs and change on the same edge (zero skew between them).
REQ-026 A digit code greater than 9 SHALL display SEG_OFF, regardless of the decoder output for that code.
REQ-027 With blank_lz=1, digit i (i=3..1) SHALL show SEG_OFF when it and all higher digits are 0; digit 0 is never blanked.
REQ-028 blank_lz SHALL be sampled combinationally each SHOW cycle, with no frame latency.

Reset
REQ-029 On rst=1 at a clock edge, the state SHALL be OFF, idx=0, and counters 0.
REQ-030 On reset, the display and pending registers SHALL be 16'h0000, ready=1, an=4'b1111, seg=SEG_OFF, and frame_start=0.
REQ-031 Reset mid-frame SHALL discard any pending value; the first frame after reset shows the display register value 0000.

Structure
REQ-032 Package seg7_pkg SHALL hold SEG_OFF, the state enumeration, and NUM_DIGITS=4.
REQ-033 The block SHALL instantiate exactly one bcd_to_7seg (ports BCD, seg) as its only sub-module.

Verification (TICK_DIV=8, DEAD_CYC=2)
REQ-034 Reset, then en=1, then load 16'h1234 -> the first frame shows 0000; frame_start pulses every 40 cycles; the second frame shows an=1110 with seg=dec(4), then 1101 with dec(3), 1011 with dec(2), 0111 with dec(1), each for 8 cycles after a 2-cycle all-off gap.
REQ-035 Load 16'h0007 with blank_lz=1 -> digits 3..1 show SEG_OFF and digit 0 shows dec(7); with blank_lz=0, digits 3..1 show dec(0).
REQ-036 Load 16'h5678, then load 16'h9999 before the frame boundary -> ready=0 after the first load, the second load is ignored, and 5678 is displayed.
REQ-037 Load 16'h00A0 -> digit 1 shows SEG_OFF; digit 0 shows dec(0).
REQ-038 Drop en for 1 cycle mid-SHOW at idx=2 -> an=1111 the next cycle; on re-enable, BLANK with idx=0 and a frame_start pulse.
REQ-039 Assert rst mid-frame with a pending value held -> the next cycle gives an=1111, seg=SEG_OFF, ready=1, and the display later shows 0000.
